// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler
// Arbitrates one tag memory array between host read/write requests and periodic
// row refresh. Only one operation runs at a time. Host traffic wins over a pending
// refresh until that refresh has waited DEFER_MAX cycles.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_enabled                 low = no new operation is started
//   i_refresh_tick            one-cycle refresh request pulse
//   i_req_*  / o_req_ready    host request handshake (valid && ready = accept)
//   o_rsp_valid, o_rsp_rdata  read completion pulse and held read data
//   o_mem_*, i_mem_rdata      array access strobes, refresh strobe and row
//   o_busy                    operation in flight or refresh pending
//   o_refresh_overrun         sticky: tick arrived while a refresh was pending
module mem_access_scheduler #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ROW_W          = 3,
  parameter int unsigned ACCESS_CYCLES  = 2,
  parameter int unsigned REFRESH_CYCLES = 2,
  parameter int unsigned DEFER_MAX      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enabled,
  input  logic              i_refresh_tick,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_refresh,
  output logic [ROW_W-1:0]  o_mem_row,
  output logic              o_busy,
  output logic              o_refresh_overrun
);

  localparam int unsigned MaxCycles = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES
                                                                        : REFRESH_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned DefW = (DEFER_MAX > 0) ? $clog2(DEFER_MAX + 1) : 1;
  localparam logic [CntW-1:0] AccLast  = CntW'(ACCESS_CYCLES - 1);
  localparam logic [CntW-1:0] RefLast  = CntW'(REFRESH_CYCLES - 1);
  localparam logic [DefW-1:0] DeferMax = DefW'(DEFER_MAX);

  typedef enum logic [1:0] {StIdle, StAccess, StRefresh} state_e;

  state_e            r_state;
  logic              r_pending;
  logic [DefW-1:0]   r_defer_cnt;
  logic [CntW-1:0]   r_op_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_refresh;
  logic [ROW_W-1:0]  r_mem_row;
  logic              r_overrun;

  logic w_idle_run;
  logic w_urgent;
  logic w_refresh_due;
  logic w_go_refresh;
  logic w_accept;

  assign w_idle_run    = i_enabled && (r_state == StIdle);
  assign w_urgent      = r_pending && (r_defer_cnt >= DeferMax);
  // A pending refresh also goes first whenever the host has nothing to offer.
  assign w_refresh_due = w_urgent || (r_pending && !i_req_valid);
  assign w_go_refresh  = w_idle_run && w_refresh_due;
  // Gated by reset so every output reads 0 while reset is held.
  assign o_req_ready   = i_reset && w_idle_run && !w_refresh_due;
  assign w_accept      = o_req_ready && i_req_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= StIdle;
      r_pending     <= 1'b0;
      r_defer_cnt   <= '0;
      r_op_cnt      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_refresh <= 1'b0;
      r_mem_row     <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      // A tick in the cycle the refresh is taken queues the next one, not an overrun.
      if (i_refresh_tick) begin
        r_pending <= 1'b1;
        if (r_pending && !w_go_refresh) begin
          r_overrun <= 1'b1;
        end
      end else if (w_go_refresh) begin
        r_pending <= 1'b0;
      end

      if (w_go_refresh) begin
        r_defer_cnt <= '0;
      end else if (r_pending && (r_state != StRefresh) && (r_defer_cnt < DeferMax)) begin
        r_defer_cnt <= r_defer_cnt + DefW'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (w_go_refresh) begin
            r_state       <= StRefresh;
            r_mem_refresh <= 1'b1;
            r_op_cnt      <= '0;
          end else if (w_accept) begin
            r_state     <= StAccess;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_req_write;
            r_mem_addr  <= i_req_addr;
            r_mem_wdata <= i_req_wdata;
            r_op_cnt    <= '0;
          end
        end
        StAccess: begin
          if (r_op_cnt == AccLast) begin
            r_state  <= StIdle;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (!r_mem_we) begin
              r_rsp_rdata <= i_mem_rdata;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            r_op_cnt <= r_op_cnt + CntW'(1);
          end
        end
        StRefresh: begin
          if (r_op_cnt == RefLast) begin
            r_state       <= StIdle;
            r_mem_refresh <= 1'b0;
            r_mem_row     <= r_mem_row + ROW_W'(1);
          end else begin
            r_op_cnt <= r_op_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_rdata       = r_rsp_rdata;
  assign o_mem_en          = r_mem_en;
  assign o_mem_we          = r_mem_we;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_mem_refresh     = r_mem_refresh;
  assign o_mem_row         = r_mem_row;
  assign o_busy            = (r_state != StIdle) || r_pending;
  assign o_refresh_overrun = r_overrun;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Bench for mem_access_scheduler: a cycle model based on "operation in flight with
// N cycles left" is compared against every DUT output at each falling edge, and
// directed scenarios add literal checks that pin the model.
module tb_mem_access_scheduler;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int AC = 2;
  localparam int RC = 2;
  localparam int DM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          tick = 1'b0;
  logic          rv = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] mrdata = '0;

  logic          req_ready, rsp_valid, mem_en, mem_we, mem_refresh, busy, overrun;
  logic [DW-1:0] rsp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_row;

  mem_access_scheduler dut (
    .i_clk             (clk),
    .i_reset           (rst_n),
    .i_enabled         (en),
    .i_refresh_tick    (tick),
    .i_req_valid       (rv),
    .i_req_write       (we),
    .i_req_addr        (addr),
    .i_req_wdata       (wdata),
    .o_req_ready       (req_ready),
    .o_rsp_valid       (rsp_valid),
    .o_rsp_rdata       (rsp_rdata),
    .o_mem_en          (mem_en),
    .o_mem_we          (mem_we),
    .o_mem_addr        (mem_addr),
    .o_mem_wdata       (mem_wdata),
    .i_mem_rdata       (mrdata),
    .o_mem_refresh     (mem_refresh),
    .o_mem_row         (mem_row),
    .o_busy            (busy),
    .o_refresh_overrun (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = host access, 2 = refresh; m_left = cycles still to run.
  int            m_mode = 0;
  int            m_left = 0;
  bit            m_pend = 0;
  int            m_wait = 0;
  bit            m_ovr = 0;
  logic [RW-1:0] m_row = '0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_rsp = 0;

  function automatic bit refresh_due();
    return (m_pend && m_wait >= DM) || (m_pend && !rv);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_pend = 0; m_wait = 0; m_ovr = 0; m_row = '0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_rsp = 0;
    end else begin
      bit go;
      bit acc;
      int old_mode;
      old_mode = m_mode;
      go  = en && m_mode == 0 && refresh_due();
      acc = en && m_mode == 0 && !refresh_due() && rv;
      if (go) m_wait = 0;
      else if (m_pend && old_mode != 2 && m_wait < DM) m_wait++;
      if (tick) begin
        if (m_pend && !go) m_ovr = 1;
        m_pend = 1;
      end else if (go) begin
        m_pend = 0;
      end
      m_rsp = 0;
      if (m_mode == 0) begin
        if (go) begin
          m_mode = 2; m_left = RC;
        end else if (acc) begin
          m_mode = 1; m_left = AC; m_we = we; m_addr = addr; m_wdata = wdata;
        end
      end else if (m_left == 1) begin
        if (m_mode == 1 && !m_we) begin
          m_rdata = mrdata; m_rsp = 1;
        end
        if (m_mode == 2) m_row = m_row + 1'b1;
        m_mode = 0;
      end else begin
        m_left--;
      end
    end
  end

  // Per-cycle compare plus simple event recording for the directed checks.
  int   nref = 0;
  int   nref_cyc = 0;
  int   nrsp = 0;
  logic prev_ref = 1'b0;
  int   row_q[$];

  always @(negedge clk) begin
    chk("ready", req_ready, rst_n && en && m_mode == 0 && !refresh_due());
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("mem_en", mem_en, m_mode == 1);
    chk("mem_we", mem_we, m_mode == 1 && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_refresh", mem_refresh, m_mode == 2);
    chk("mem_row", mem_row, m_row);
    chk("busy", busy, m_mode != 0 || m_pend);
    chk("overrun", overrun, m_ovr);
    chk("en_ref_excl", mem_en & mem_refresh, 1'b0);
    if (mem_refresh && !prev_ref) begin
      nref++;
      row_q.push_back(int'(mem_row));
    end
    if (mem_refresh) nref_cyc++;
    if (rsp_valid) nrsp++;
    prev_ref = mem_refresh;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int exp_rows[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int c0, c1;

  initial begin
    // Reset held with random inputs.
    repeat (4) begin
      step();
      en = 1'($urandom); tick = 1'($urandom); rv = 1'($urandom); we = 1'($urandom);
      addr = AW'($urandom); wdata = DW'($urandom); mrdata = DW'($urandom);
    end
    chk("rst_mem_en", mem_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_row", mem_row, 0);
    en = 1; tick = 0; rv = 0; we = 0; addr = '0; wdata = '0; mrdata = '0;
    step();
    rst_n = 1;
    #1 chk("ready_after_reset", req_ready, 1);

    // Read of 0x15 returning 0xBEEF.
    step();
    rv = 1; we = 0; addr = 6'h15; mrdata = 16'hBEEF;
    step(); rv = 0;
    chk("rd_en1", mem_en, 1); chk("rd_addr", mem_addr, 6'h15); chk("rd_we", mem_we, 0);
    step(); chk("rd_en2", mem_en, 1);
    step(); chk("rd_rsp", rsp_valid, 1); chk("rd_data", rsp_rdata, 16'hBEEF);
    chk("rd_en_off", mem_en, 0);
    step(); chk("rd_rsp_once", rsp_valid, 0);

    // Write of 0x1234 to 0x2A.
    rv = 1; we = 1; addr = 6'h2A; wdata = 16'h1234;
    step(); rv = 0; we = 0;
    chk("wr_en", mem_en, 1); chk("wr_we", mem_we, 1); chk("wr_data", mem_wdata, 16'h1234);
    c0 = nrsp;
    step(); step(); step();
    chk("wr_no_rsp", nrsp - c0, 0); chk("wr_done", mem_en, 0);

    // Nine widely spaced ticks: rows 0..7 then wrap to 0.
    row_q.delete(); c0 = nref; c1 = nref_cyc;
    for (int i = 0; i < 9; i++) begin
      tick = 1; step(); tick = 0;
      repeat (9) step();
    end
    repeat (3) step();
    chk("wrap_bursts", nref - c0, 9);
    chk("wrap_cycles", nref_cyc - c1, 18);
    chk("wrap_count", row_q.size(), 9);
    for (int i = 0; i < 9; i++) chk("wrap_row", (i < row_q.size()) ? row_q[i] : -1, exp_rows[i]);
    chk("wrap_no_overrun", overrun, 0);

    // Starvation: continuous reads, one tick; refresh forced at defer limit.
    rv = 1; we = 0; addr = 6'h05; tick = 1;
    step(); tick = 0;
    repeat (5) step();
    chk("starve_ready_low", req_ready, 0); chk("starve_busy", busy, 1);
    step(); chk("starve_refresh", mem_refresh, 1); chk("starve_row", mem_row, 1);
    step(); step(); chk("starve_resume_ready", req_ready, 1);
    step(); chk("starve_resume_en", mem_en, 1); rv = 0;
    repeat (4) step();

    // Asynchronous reset in the middle of a read.
    rv = 1; we = 0; addr = 6'h33;
    step(); rv = 0;
    c0 = nrsp;
    #1 rst_n = 0;
    #1 chk("abort_en", mem_en, 0); chk("abort_row", mem_row, 0); chk("abort_busy", busy, 0);
    step(); step();
    rst_n = 1;
    step(); step();
    chk("abort_no_rsp", nrsp - c0, 0);

    // Disabled: two ticks cause an overrun and no refresh; enabling runs one refresh.
    en = 0; c0 = nref;
    tick = 1; step(); tick = 0;
    step(); step();
    tick = 1; step(); tick = 0;
    chk("ovr_set", overrun, 1); chk("ovr_no_ref", mem_refresh, 0); chk("ovr_ready", req_ready, 0);
    repeat (4) step();
    chk("ovr_still_no_ref", nref - c0, 0);
    row_q.delete();
    en = 1;
    repeat (6) step();
    chk("en_one_ref", nref - c0, 1);
    chk("en_ref_row", (row_q.size() > 0) ? row_q[0] : -1, 0);
    chk("en_row_after", mem_row, 1);
    chk("en_ovr_sticky", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
